// File: rtl/load_store_unit.sv
// load_store_unit
//   Sequences one load or store at a time between the pipeline and a
//   word-addressed data memory that reads combinationally and writes on clk.
//   Byte and half stores are read-modify-write: the old word is read on the
//   final ACCESS cycle and rewritten in MERGE with only the target lane changed.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_*               request from the pipeline (valid/ready)
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores/misaligned), held
//   resp_misaligned     request rejected (misaligned or illegal size), held
//   mem_we/addr/wdata   data memory write enable, word address, write data
//   mem_rdata           data memory read data (combinational)
//   dbg_state           current FSM state, for checkers
//
// Handshake: a request transfers on a rising clk edge where req_valid=1 and
// req_ready=1. req_ready is high only in IDLE; the request fields are latched
// at that edge and the request inputs are ignored until the unit is IDLE again.
module load_store_unit #(
  parameter int WORD_SIZE   = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_misaligned,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [1:0]           dbg_state
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WORD_SIZE-1:0] BYTE_MASK = {{(WORD_SIZE-8){1'b0}}, 8'hFF};
  localparam logic [WORD_SIZE-1:0] HALF_MASK = {{(WORD_SIZE-16){1'b0}}, 16'hFFFF};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   r_we;
  logic [1:0]             r_size;
  logic                   r_unsigned;
  logic [WORD_SIZE-1:0]   r_addr;
  logic [WORD_SIZE-1:0]   r_wdata;
  logic [WORD_SIZE-1:0]   merge_word;

  logic                   last_access;
  logic                   word_store;
  logic                   misaligned_in;
  logic [4:0]             lane_shift;
  logic [WORD_SIZE-1:0]   rd_lane;
  logic [WORD_SIZE-1:0]   load_ext;
  logic [WORD_SIZE-1:0]   lane_mask;
  logic [WORD_SIZE-1:0]   merged;

  always_comb begin
    last_access   = (state == ACCESS) && (cnt == '0);
    word_store    = r_we && (r_size == 2'b10);
    misaligned_in = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    // Little-endian lanes: byte n at bits [8n+7:8n], half h at [16h+15:16h].
    lane_shift = 5'd0;
    lane_mask  = BYTE_MASK;
    case (r_size)
      2'b00: begin
        lane_shift = {r_addr[1:0], 3'b000};
        lane_mask  = BYTE_MASK;
      end
      2'b01: begin
        lane_shift = {r_addr[1], 4'b0000};
        lane_mask  = HALF_MASK;
      end
      default: begin
        lane_shift = 5'd0;
        lane_mask  = BYTE_MASK;
      end
    endcase

    rd_lane = mem_rdata >> lane_shift;
    case (r_size)
      2'b00:   load_ext = r_unsigned ? {{(WORD_SIZE-8){1'b0}}, rd_lane[7:0]}
                                     : {{(WORD_SIZE-8){rd_lane[7]}}, rd_lane[7:0]};
      2'b01:   load_ext = r_unsigned ? {{(WORD_SIZE-16){1'b0}}, rd_lane[15:0]}
                                     : {{(WORD_SIZE-16){rd_lane[15]}}, rd_lane[15:0]};
      default: load_ext = mem_rdata;
    endcase

    merged = (mem_rdata & ~(lane_mask << lane_shift)) |
             ((r_wdata & lane_mask) << lane_shift);
  end

  // Memory-side outputs decode directly from state so that an asynchronous
  // reset drops mem_we in the same instant.
  always_comb begin
    req_ready = (state == IDLE);
    dbg_state = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if ((state == ACCESS) || (state == MERGE)) begin
      mem_addr = {2'b00, r_addr[WORD_SIZE-1:2]};
    end
    if (last_access && word_store) begin
      mem_we    = 1'b1;
      mem_wdata = r_wdata;
    end else if (state == MERGE) begin
      mem_we    = 1'b1;
      mem_wdata = merge_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      r_we            <= 1'b0;
      r_size          <= 2'b00;
      r_unsigned      <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      merge_word      <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            if (misaligned_in) begin
              state           <= RESP;
              resp_valid      <= 1'b1;
              resp_misaligned <= 1'b1;
              resp_rdata      <= '0;
            end else begin
              state <= ACCESS;
              cnt   <= CW'(MEM_LATENCY - 1);
            end
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!r_we) begin
            state           <= RESP;
            resp_valid      <= 1'b1;
            resp_misaligned <= 1'b0;
            resp_rdata      <= load_ext;
          end else if (word_store) begin
            state           <= RESP;
            resp_valid      <= 1'b1;
            resp_misaligned <= 1'b0;
            resp_rdata      <= '0;
          end else begin
            merge_word <= merged;
            state      <= MERGE;
          end
        end
        MERGE: begin
          state           <= RESP;
          resp_valid      <= 1'b1;
          resp_misaligned <= 1'b0;
          resp_rdata      <= '0;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
